// File: rtl/shift_count_sequencer.sv
// Multi-pass sequencer that breaks a shift/rotate-by-count into ALU passes of at most 15 steps.
// Optional SHSEQ_COUNT_MASK_EN: mask the count to 5 bits before use (186+ style); default uses all 8 bits.
module shift_count_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op_in,
    input  logic        v_in,
    input  logic [15:0] data_in,
    input  logic [7:0]  count_in,
    input  logic        cf_in,
    output logic [15:0] alu_opA,
    output logic [3:0]  alu_opB,
    output logic        alu_V,
    output logic        alu_Cin,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_R,
    input  logic        alu_CF,
    input  logic        alu_OF,
    output logic        busy,
    output logic        done,
    output logic        flags_we,
    output logic [15:0] result,
    output logic        cf_out,
    output logic        of_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] acc;
    logic [7:0]  rem;
    logic        carry;
    logic        ovf;
    logic        zcnt;
    logic [2:0]  op_q;
    logic        v_q;

    logic [7:0]  count_eff;
    logic [3:0]  chunk;
    logic [7:0]  rem_nx;

`ifdef SHSEQ_COUNT_MASK_EN
    assign count_eff = {3'b000, count_in[4:0]};
`else
    assign count_eff = count_in;
`endif

    // Each pass covers up to 15 steps, the most the 4-bit ALU count can express.
    always_comb begin
        chunk  = (rem > 8'd15) ? 4'd15 : rem[3:0];
        rem_nx = rem - {4'd0, chunk};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (count_eff == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rem_nx == 8'd0) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Carry is fed back between passes so long rotates through carry chain correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= 16'd0;
            rem   <= 8'd0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            zcnt  <= 1'b0;
            op_q  <= 3'd0;
            v_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        v_q   <= v_in;
                        acc   <= data_in;
                        rem   <= count_eff;
                        carry <= cf_in;
                        ovf   <= 1'b0;
                        zcnt  <= (count_eff == 8'd0);
                    end
                end
                RUN: begin
                    acc   <= alu_R;
                    carry <= alu_CF;
                    ovf   <= alu_OF;
                    rem   <= rem_nx;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        alu_opA  = acc;
        alu_opB  = (state == RUN) ? chunk : 4'd0;
        alu_V    = v_q;
        alu_Cin  = carry;
        alu_op   = op_q;
        busy     = (state != IDLE);
        done     = (state == DONE);
        flags_we = (state == DONE) && !zcnt;
        result   = acc;
        cf_out   = carry;
        of_out   = ovf;
    end

endmodule

// File: tb/tb_shift_count_sequencer.sv
// Directed bench for shift_count_sequencer; a behavioural shift/rotate ALU closes the loop.
module tb_shift_count_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op_in;
    logic        v_in;
    logic [15:0] data_in;
    logic [7:0]  count_in;
    logic        cf_in;
    logic [15:0] alu_opA;
    logic [3:0]  alu_opB;
    logic        alu_V;
    logic        alu_Cin;
    logic [2:0]  alu_op;
    logic [15:0] alu_R;
    logic        alu_CF;
    logic        alu_OF;
    logic        busy;
    logic        done;
    logic        flags_we;
    logic [15:0] result;
    logic        cf_out;
    logic        of_out;

    int errors = 0;
    int checks = 0;

    shift_count_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op_in(op_in), .v_in(v_in),
        .data_in(data_in), .count_in(count_in), .cf_in(cf_in),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_V(alu_V), .alu_Cin(alu_Cin),
        .alu_op(alu_op), .alu_R(alu_R), .alu_CF(alu_CF), .alu_OF(alu_OF),
        .busy(busy), .done(done), .flags_we(flags_we), .result(result),
        .cf_out(cf_out), .of_out(of_out)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: n single steps; byte mode leaves the upper byte untouched.
    function automatic logic [17:0] alu_model(input logic [2:0] op, input logic v,
                                              input logic [15:0] a, input logic [3:0] n,
                                              input logic cin);
        logic [15:0] x;
        logic        c;
        logic        msb;
        logic        b;
        logic        o;
        x = a;
        c = cin;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(n)) begin
                msb = v ? x[15] : x[7];
                if (!op[0]) begin
                    b = (op == 3'b000) ? msb : ((op == 3'b010) ? c : 1'b0);
                    c = msb;
                    x = {x[14:0], b};
                    if (!v) x[15:8] = a[15:8];
                end else begin
                    b = (op == 3'b001) ? x[0] : ((op == 3'b011) ? c : ((op == 3'b111) ? msb : 1'b0));
                    c = x[0];
                    x = x >> 1;
                    if (v) begin
                        x[15] = b;
                    end else begin
                        x[7]     = b;
                        x[15:8]  = a[15:8];
                    end
                end
            end
        end
        if (n == 4'd0)   o = 1'b0;
        else if (!op[0]) o = (v ? x[15] : x[7]) ^ c;
        else             o = v ? (x[15] ^ x[14]) : (x[7] ^ x[6]);
        return {o, c, x};
    endfunction

    always_comb {alu_OF, alu_CF, alu_R} = alu_model(alu_op, alu_V, alu_opA, alu_opB, alu_Cin);

    // Presents one start request at the falling edge and returns #1 after the accepting edge.
    task automatic do_start(input logic [2:0] op, input logic v, input logic [15:0] d,
                            input logic [7:0] cnt, input logic cf);
        @(negedge clk);
        op_in = op; v_in = v; data_in = d; count_in = cnt; cf_in = cf; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op_in = 3'd0; v_in = 1'b0;
        data_in = 16'd0; count_in = 8'd0; cf_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, flags_we} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl got=%b want=000", {busy, done, flags_we}); end
        checks++; if ({result, cf_out, of_out} !== 18'd0) begin errors++; $display("[TB] FAIL reset_out got=%h want=0", {result, cf_out, of_out}); end
        checks++; if (alu_opB !== 4'd0) begin errors++; $display("[TB] FAIL reset_opB got=%0d want=0", alu_opB); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, result} !== 17'd0) begin errors++; $display("[TB] FAIL post_reset got=%h want=0", {busy, result}); end
    endtask

    task automatic test_rol_word;
        do_start(3'b000, 1'b1, 16'h8001, 8'd1, 1'b0);
        checks++; if ({busy, done, alu_opB} !== {1'b1, 1'b0, 4'd1}) begin errors++; $display("[TB] FAIL rol1_run got=%b want=1_0_0001", {busy, done, alu_opB}); end
        @(posedge clk); #1;
        checks++; if ({done, flags_we} !== 2'b11) begin errors++; $display("[TB] FAIL rol1_done got=%b want=11", {done, flags_we}); end
        checks++; if ({result, cf_out, of_out} !== {16'h0003, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL rol1_res got=%h/%b/%b want=0003/1/1", result, cf_out, of_out); end
        @(posedge clk); #1;
        checks++; if ({busy, done, result} !== {2'b00, 16'h0003}) begin errors++; $display("[TB] FAIL rol1_hold got=%b%b/%h want=00/0003", busy, done, result); end
    endtask

    task automatic test_multi_chunk;
        do_start(3'b000, 1'b1, 16'h0001, 8'd20, 1'b0);
        checks++; if (alu_opB !== 4'd15) begin errors++; $display("[TB] FAIL rol20_opB1 got=%0d want=15", alu_opB); end
        @(posedge clk); #1;
        checks++; if ({alu_opB, result, done} !== {4'd5, 16'h8000, 1'b0}) begin errors++; $display("[TB] FAIL rol20_pass2 got=%0d/%h/%b want=5/8000/0", alu_opB, result, done); end
        @(posedge clk); #1;
        checks++; if ({done, result, cf_out} !== {1'b1, 16'h0010, 1'b0}) begin errors++; $display("[TB] FAIL rol20_done got=%b/%h/%b want=1/0010/0", done, result, cf_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_count;
        do_start(3'b000, 1'b1, 16'h1234, 8'd0, 1'b1);
        checks++; if ({busy, done, flags_we} !== 3'b110) begin errors++; $display("[TB] FAIL zero_ctrl got=%b want=110", {busy, done, flags_we}); end
        checks++; if ({result, cf_out, of_out} !== {16'h1234, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL zero_res got=%h/%b/%b want=1234/1/0", result, cf_out, of_out); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle got=%b want=0", busy); end
    endtask

    task automatic test_rcl_rcr_chain;
        do_start(3'b010, 1'b1, 16'h8000, 8'd17, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({done, result, cf_out} !== {1'b1, 16'h8000, 1'b0}) begin errors++; $display("[TB] FAIL rcl17 got=%b/%h/%b want=1/8000/0", done, result, cf_out); end
        @(posedge clk); #1;
        do_start(3'b011, 1'b1, 16'h4000, 8'd16, 1'b0);
        @(posedge clk); #1;
        checks++; if ({result, cf_out} !== {16'h0000, 1'b1}) begin errors++; $display("[TB] FAIL rcr16_mid got=%h/%b want=0000/1", result, cf_out); end
        @(posedge clk); #1;
        checks++; if ({done, result, cf_out} !== {1'b1, 16'h8000, 1'b0}) begin errors++; $display("[TB] FAIL rcr16_done got=%b/%h/%b want=1/8000/0", done, result, cf_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_sar_byte;
        do_start(3'b111, 1'b0, 16'h1280, 8'd3, 1'b1);
        checks++; if ({alu_op, alu_V, alu_opB} !== {3'b111, 1'b0, 4'd3}) begin errors++; $display("[TB] FAIL sar_alu got=%b/%b/%0d want=111/0/3", alu_op, alu_V, alu_opB); end
        @(posedge clk); #1;
        checks++; if ({done, result, cf_out, of_out} !== {1'b1, 16'h12F0, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL sar_done got=%b/%h/%b/%b want=1/12f0/0/0", done, result, cf_out, of_out); end
        checks++; if ({alu_opB, alu_op, alu_opA} !== {4'd0, 3'b111, 16'h12F0}) begin errors++; $display("[TB] FAIL sar_hold_alu got=%0d/%b/%h want=0/111/12f0", alu_opB, alu_op, alu_opA); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int dcnt;
        int cyc;
        int passes_exp;
        dcnt = 0;
        do_start(3'b000, 1'b1, 16'h0001, 8'd40, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, flags_we, result, cf_out, of_out, alu_opB} !== 25'd0) begin errors++; $display("[TB] FAIL midrst_out got=%b%b%b/%h/%b%b/%0d want=0", busy, done, flags_we, result, cf_out, of_out, alu_opB); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || flags_we) dcnt++;
        end
        checks++; if (dcnt !== 0) begin errors++; $display("[TB] FAIL midrst_nodone got=%0d want=0", dcnt); end
`ifdef SHSEQ_COUNT_MASK_EN
        passes_exp = 1;
`else
        passes_exp = 3;
`endif
        do_start(3'b000, 1'b1, 16'h0001, 8'h21, 1'b0);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== passes_exp + 1) begin errors++; $display("[TB] FAIL count21_passes got=%0d want=%0d", cyc - 1, passes_exp); end
        checks++; if (result !== 16'h0002) begin errors++; $display("[TB] FAIL count21_res got=%h want=0002", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int  dcnt;
        int  falls;
        logic prev;
        dcnt = 0; falls = 0; prev = 1'b1;
        do_start(3'b000, 1'b1, 16'h0001, 8'd20, 1'b0);
        start = 1'b1; data_in = 16'hFFFF; count_in = 8'd0; cf_in = 1'b1;
        for (int c = 2; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 4) start = 1'b0;
            if (done) dcnt++;
            if (prev && !busy) falls++;
            prev = busy;
        end
        checks++; if (dcnt !== 1) begin errors++; $display("[TB] FAIL b2b_done_pulses got=%0d want=1", dcnt); end
        checks++; if (falls !== 1) begin errors++; $display("[TB] FAIL b2b_busy_falls got=%0d want=1", falls); end
        checks++; if ({busy, result} !== {1'b0, 16'h0010}) begin errors++; $display("[TB] FAIL b2b_result got=%b/%h want=0/0010", busy, result); end
    endtask

    initial begin
        test_reset;
        test_rol_word;
        test_multi_chunk;
        test_zero_count;
        test_rcl_rcr_chain;
        test_sar_byte;
        test_reset_mid_run;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_count_sequencer.md
SHIFT_COUNT_SEQUENCER -- requirements
Module: shift_count_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a shift/rotate-by-count.
REQ-004 SHALL have ports op_in input 3 (op encoding 000 ROL to 111 SAR) and v_in input 1 (V size select).
REQ-005 SHALL have ports data_in input 16 (operand), count_in input 8 (CL count) and cf_in input 1 (current carry flag).
REQ-006 SHALL have ports alu_opA output 16, alu_opB output 4, alu_V output 1, alu_Cin output 1 and alu_op output 3, which drive the shift/rotate ALU.
REQ-007 SHALL have ports alu_R input 16, alu_CF input 1 and alu_OF input 1, which return the combinational ALU results.
REQ-008 SHALL have ports busy output 1, done output 1 (one-cycle pulse), flags_we output 1 (pulse with done), result output 16, cf_out output 1 and of_out output 1.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE; busy=1 in RUN and DONE.
REQ-010 IDLE: start=1 SHALL latch op_in, v_in, data_in (acc), count_in (rem) and cf_in (carry).
REQ-011 IDLE: start with count_in!=0 SHALL go to RUN; with count_in=0 SHALL go to DONE with acc=data_in, carry=cf_in, zero-count flag set.
REQ-012 RUN: chunk = min(rem,15); alu_opA=acc, alu_opB=chunk, alu_Cin=carry; alu_op and alu_V SHALL equal the latched values.
REQ-013 RUN, each clock: acc<=alu_R, carry<=alu_CF, ovf<=alu_OF, rem<=rem-chunk; SHALL go to DONE when rem-chunk=0, else stay in RUN.
REQ-014 The carry chaining of REQ-013 SHALL make RCL/RCR over more than 15 steps equal a single-step iteration of count_in steps.
REQ-015 RUN SHALL last ceil(count_in/15) cycles; count_in=255 SHALL take 17 passes.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE.
REQ-017 DONE: flags_we=1 unless the zero-count flag is set; zero count SHALL leave flags unchanged, so cf_out=cf_in and of_out=0.
REQ-018 result, cf_out and of_out SHALL reflect acc, carry and ovf, and SHALL hold until the next accepted start.
REQ-019 start while busy SHALL be ignored, with no queuing.
REQ-020 Outside RUN, alu_opB=0 and the other alu_* outputs SHALL hold their latched values.
REQ-021 start in the DONE cycle SHALL be ignored; a new start SHALL be accepted only in IDLE.

Reset
REQ-022 rst=1 SHALL force state=IDLE at once, regardless of clk.
REQ-023 rst=1 SHALL clear acc, rem, carry, ovf, zero-count flag and latched op/V to 0.
REQ-024 During and after reset, busy=done=flags_we=0 and result=0, cf_out=0, of_out=0.
REQ-025 Reset mid-RUN SHALL abandon the operation without a done or flags_we pulse.

Configuration
REQ-026 With macro SHSEQ_COUNT_MASK_EN defined, count_in SHALL be masked to count_in[4:0] before the zero test and latching (186+ behaviour).
REQ-027 Without SHSEQ_COUNT_MASK_EN, the full 8-bit count SHALL be used (8088 behaviour).

Verification
REQ-028 Word mode (v_in=1), ROL, data_in=0x8001, count_in=1 -> one RUN cycle, done 2 clocks after start, result=0x0003, cf_out=1, flags_we=1.
REQ-029 ROL, data_in=0x0001, count_in=20 -> alu_opB=15 then 5, result=0x0010, done on 3rd clock after start.
REQ-030 count_in=0, cf_in=1, data_in=0x1234 -> done next clock, result=0x1234, cf_out=1, flags_we=0.
REQ-031 RCL, count_in=17, data_in=0x8000, cf_in=0 -> result equals a 17-step reference model (0x8000), carry chained across both passes.
REQ-032 rst asserted in 2nd RUN cycle of count_in=40 -> outputs 0 immediately, no done; start with count_in=0x21 -> 3 passes without the macro, 1 pass with SHSEQ_COUNT_MASK_EN.
REQ-033 start pulsed during RUN and DONE -> ignored; busy falls once, exactly one done pulse.
